// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered status flags and sticky overflow/underflow.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered DataOut.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WD,
  input  logic                     RD,
  input  logic [WIDTH-1:0]         Data,
  input  logic                     ClrErr,
  output logic [WIDTH-1:0]         DataOut,
  output logic                     Empty,
  output logic                     Full,
  output logic                     AlmostEmpty,
  output logic                     AlmostFull,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          rd_acc,   wr_acc;

  // Status flags decode the registered count only, so they move on the same edge as Count.
  assign Empty       = (count_q == '0);
  assign Full        = (count_q == FULL_CNT);
  assign AlmostEmpty = (count_q <= AE_CNT);
  assign AlmostFull  = (count_q >= AF_CNT);
  assign Count       = count_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;

  // A read frees a slot in the same cycle, so a write at Full is still accepted alongside it.
  assign rd_acc = RD && !Empty;
  assign wr_acc = WD && (!Full || rd_acc);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as ClrErr takes priority over the clear.
    ovf_d = (WD && !wr_acc) || (ovf_q && !ClrErr);
    udf_d = (RD && !rd_acc) || (udf_q && !ClrErr);
  end

  // NOTE: storage has no reset; the pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= Data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; RD acknowledges the word already on DataOut.
  assign DataOut = Empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= '0;
    else      dout_q <= dout_d;
  end

  assign DataOut = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
// directed vector table, wrap and async-reset sequences, and random traffic against a queue model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         WD     = 1'b0;
  logic         RD     = 1'b0;
  logic         ClrErr = 1'b0;
  logic [W-1:0] Data   = '0;
  logic [W-1:0] DataOut;
  logic         Empty, Full, AlmostEmpty, AlmostFull, Overflow, Underflow;
  logic [2:0]   Count;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .WD(WD), .RD(RD), .Data(Data), .ClrErr(ClrErr),
    .DataOut(DataOut), .Empty(Empty), .Full(Full), .AlmostEmpty(AlmostEmpty),
    .AlmostFull(AlmostFull), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every status flag is derived here from the expected occupancy using the flag definitions.
  task automatic check_all(input string tag, input int cnt, input bit ovf, input bit udf,
                           input logic [W-1:0] dout);
    check({tag, ".count"},  32'(Count),       32'(cnt));
    check({tag, ".empty"},  32'(Empty),       32'(cnt == 0));
    check({tag, ".full"},   32'(Full),        32'(cnt == D));
    check({tag, ".aempty"}, 32'(AlmostEmpty), 32'(cnt <= AE));
    check({tag, ".afull"},  32'(AlmostFull),  32'(cnt >= AF));
    check({tag, ".ovf"},    32'(Overflow),    32'(ovf));
    check({tag, ".udf"},    32'(Underflow),   32'(udf));
    check({tag, ".dout"},   32'(DataOut),     32'(dout));
  endtask

  // Reference model: a plain queue of words plus the two sticky flags.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf;
  logic [W-1:0] m_dreg;

  function automatic logic [W-1:0] m_dout();
`ifdef FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : '0;
`else
    return m_dreg;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dreg = '0;
  endtask

  task automatic model_step(input bit wd, input bit rd, input bit clr, input logic [W-1:0] d);
    bit rd_ok, wr_ok;
    rd_ok = rd && (mq.size() > 0);
    wr_ok = wd && ((mq.size() < D) || rd_ok);
    if (rd_ok) m_dreg = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    m_ovf = (wd && !wr_ok) || (m_ovf && !clr);
    m_udf = (rd && !rd_ok) || (m_udf && !clr);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, return at the next falling edge.
  task automatic drive(input bit wd, input bit rd, input bit clr, input logic [W-1:0] d);
    WD = wd; RD = rd; ClrErr = clr; Data = d;
    @(posedge clk);
    @(negedge clk);
    WD = 1'b0; RD = 1'b0; ClrErr = 1'b0;
  endtask

  task automatic op(input string tag, input bit wd, input bit rd, input bit clr,
                    input logic [W-1:0] d);
    drive(wd, rd, clr, d);
    model_step(wd, rd, clr, d);
    check_all(tag, mq.size(), m_ovf, m_udf, m_dout());
  endtask

  task automatic do_reset();
    rst = 1'b0; WD = 1'b0; RD = 1'b0; ClrErr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit           wd, rd, clr;
    logic [W-1:0] data;
    int           cnt;
    bit           ovf, udf;
    logic [W-1:0] dreg;   // expected DataOut, registered read mode
    logic [W-1:0] dfwft;  // expected DataOut, fall-through read mode
  } vec_t;

  vec_t tbl[25];

  initial begin
    tbl[0]  = '{1, 0, 0, 8'h11, 1, 0, 0, 8'h00, 8'h11};
    tbl[1]  = '{1, 0, 0, 8'h22, 2, 0, 0, 8'h00, 8'h11};
    tbl[2]  = '{1, 0, 0, 8'h33, 3, 0, 0, 8'h00, 8'h11};
    tbl[3]  = '{1, 0, 0, 8'h44, 4, 0, 0, 8'h00, 8'h11};
    tbl[4]  = '{1, 0, 0, 8'h55, 4, 1, 0, 8'h00, 8'h11};
    tbl[5]  = '{0, 1, 0, 8'h00, 3, 1, 0, 8'h11, 8'h22};
    tbl[6]  = '{0, 1, 0, 8'h00, 2, 1, 0, 8'h22, 8'h33};
    tbl[7]  = '{0, 1, 0, 8'h00, 1, 1, 0, 8'h33, 8'h44};
    tbl[8]  = '{0, 1, 0, 8'h00, 0, 1, 0, 8'h44, 8'h00};
    tbl[9]  = '{0, 0, 1, 8'h00, 0, 0, 0, 8'h44, 8'h00};
    tbl[10] = '{1, 0, 0, 8'h11, 1, 0, 0, 8'h44, 8'h11};
    tbl[11] = '{1, 0, 0, 8'h22, 2, 0, 0, 8'h44, 8'h11};
    tbl[12] = '{1, 0, 0, 8'h33, 3, 0, 0, 8'h44, 8'h11};
    tbl[13] = '{1, 0, 0, 8'h44, 4, 0, 0, 8'h44, 8'h11};
    tbl[14] = '{1, 1, 0, 8'h66, 4, 0, 0, 8'h11, 8'h22};
    tbl[15] = '{0, 1, 0, 8'h00, 3, 0, 0, 8'h22, 8'h33};
    tbl[16] = '{0, 1, 0, 8'h00, 2, 0, 0, 8'h33, 8'h44};
    tbl[17] = '{0, 1, 0, 8'h00, 1, 0, 0, 8'h44, 8'h66};
    tbl[18] = '{0, 1, 0, 8'h00, 0, 0, 0, 8'h66, 8'h00};
    tbl[19] = '{0, 1, 0, 8'h00, 0, 0, 1, 8'h66, 8'h00};
    tbl[20] = '{0, 0, 1, 8'h00, 0, 0, 0, 8'h66, 8'h00};
    tbl[21] = '{1, 1, 0, 8'h77, 1, 0, 1, 8'h66, 8'h77};
    tbl[22] = '{0, 1, 1, 8'h00, 0, 0, 0, 8'h77, 8'h00};
    tbl[23] = '{0, 1, 1, 8'h00, 0, 0, 1, 8'h77, 8'h00};
    tbl[24] = '{0, 0, 1, 8'h00, 0, 0, 0, 8'h77, 8'h00};

    // Reset state, sampled while reset is still asserted.
    #2;
    check_all("reset", 0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Directed vectors: fill, overflow, drain, clear, write+read at Full and at Empty.
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].wd, tbl[i].rd, tbl[i].clr, tbl[i].data);
`ifdef FIFO_FWFT_EN
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ovf, tbl[i].udf, tbl[i].dfwft);
`else
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ovf, tbl[i].udf, tbl[i].dreg);
`endif
    end

    // Ten write/read pairs: pointers wrap twice, order and latency must hold.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      op($sformatf("wrap_w%0d", k), 1'b1, 1'b0, 1'b0, W'(k));
`ifdef FIFO_FWFT_EN
      check($sformatf("wrap_fwft_head%0d", k), 32'(DataOut), 32'(k));
`endif
      op($sformatf("wrap_r%0d", k), 1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
      check($sformatf("wrap_reg_out%0d", k), 32'(DataOut), 32'(k));
`endif
    end

    // Reset between edges with Count=3 and Underflow set: outputs clear before the next edge.
    do_reset();
    op("ar_udf", 1'b0, 1'b1, 1'b0, 8'h00);
    op("ar_w1", 1'b1, 1'b0, 1'b0, 8'hA1);
    op("ar_w2", 1'b1, 1'b0, 1'b0, 8'hA2);
    op("ar_w3", 1'b1, 1'b0, 1'b0, 8'hA3);
    op("ar_r1", 1'b0, 1'b1, 1'b0, 8'h00);
    op("ar_w4", 1'b1, 1'b0, 1'b0, 8'hA4);
    #2 rst = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b0, 1'b0, 8'h00);
    model_reset();
    @(negedge clk);
    check_all("rst_held", 0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    op("post_rst_w", 1'b1, 1'b0, 1'b0, 8'h5A);
    op("post_rst_r", 1'b0, 1'b1, 1'b0, 8'h00);

    // Random traffic, alternating write-heavy and read-heavy phases to visit Full and Empty.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int  wprob;
      bit  wd, rd, clr;
      wprob = ((i / 40) % 2 == 0) ? 75 : 30;
      wd  = ($urandom_range(99) < wprob);
      rd  = ($urandom_range(99) < (100 - wprob));
      clr = ($urandom_range(15) == 0);
      op($sformatf("rnd%0d", i), wd, rd, clr, W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
